// File: rtl/rf_port_master_if.sv
// rf_port_master_if: command and response handshake bundle between a sequencer and rf_port_master
interface rf_port_master_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_a;
  logic [ADDR_W-1:0] cmd_b;
  logic [DATA_W-1:0] cmd_wd;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rd1;
  logic [DATA_W-1:0] rsp_rd2;
  modport master (
    output cmd_valid, cmd_write, cmd_a, cmd_b, cmd_wd, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rd1, rsp_rd2
  );
  modport slave (
    input  cmd_valid, cmd_write, cmd_a, cmd_b, cmd_wd, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rd1, rsp_rd2
  );
endinterface

// File: rtl/rf_port_master.sv
// rf_port_master: FIFO-buffered in-order initiator for a 2R/1W register file.
// Define RF_PORT_BYPASS_EN to let a command skip the empty FIFO straight into the issue stage.
module rf_port_master #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  rf_port_master_if.slave   bus,
  output logic              rf_we3_o,
  output logic [ADDR_W-1:0] rf_a1_o,
  output logic [ADDR_W-1:0] rf_a2_o,
  output logic [ADDR_W-1:0] rf_a3_o,
  output logic [DATA_W-1:0] rf_wd3_o,
  input  logic [DATA_W-1:0] rf_rd1_i,
  input  logic [DATA_W-1:0] rf_rd2_i,
  output logic              busy_o
);
  localparam int PW = $clog2(DEPTH);
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    logic [DATA_W-1:0] wd;
  } cmd_t;
  typedef enum logic [1:0] {ISS_IDLE, ISS_WRITE, ISS_READ} iss_e;
  cmd_t              mem_q [DEPTH];
  logic [PW:0]       wp_q, wp_d, rp_q, rp_d;
  iss_e              st_q, st_d;
  logic [ADDR_W-1:0] a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d, rd1_q, rd1_d, rd2_q, rd2_d;
  logic              rsp_valid_q, rsp_valid_d;
  cmd_t              inc, head, ld_cmd;
  logic              empty, full, acc, iss_ret, ld_ok, pop, byp, push, ld, capture;
  assign inc   = {bus.cmd_write, bus.cmd_a, bus.cmd_b, bus.cmd_wd};
  assign head  = mem_q[rp_q[PW-1:0]];
  assign empty = wp_q == rp_q;
  // extra pointer bit distinguishes full from empty when indices match
  assign full  = (wp_q ^ rp_q) == {1'b1, {PW{1'b0}}};
  assign acc   = bus.cmd_valid & ~full;
  // a write always retires; a read retires only when the response slot frees
  assign iss_ret = (st_q == ISS_WRITE) | ((st_q == ISS_READ) & (~rsp_valid_q | bus.rsp_ready));
  assign ld_ok   = (st_q == ISS_IDLE) | iss_ret;
  assign pop     = ld_ok & ~empty;
`ifdef RF_PORT_BYPASS_EN
  assign byp     = ld_ok & empty & acc;
`else
  assign byp     = 1'b0;
`endif
  assign push    = acc & ~byp;
  assign ld      = pop | byp;
  assign ld_cmd  = pop ? head : inc;
  assign capture = (st_q == ISS_READ) & iss_ret;
  always_comb begin
    st_d        = ld ? (ld_cmd.wr ? ISS_WRITE : ISS_READ) : (iss_ret ? ISS_IDLE : st_q);
    a1_d        = (ld & ~ld_cmd.wr) ? ld_cmd.a : a1_q;
    a2_d        = (ld & ~ld_cmd.wr) ? ld_cmd.b : a2_q;
    a3_d        = (ld & ld_cmd.wr) ? ld_cmd.a : a3_q;
    wd3_d       = (ld & ld_cmd.wr) ? ld_cmd.wd : wd3_q;
    rsp_valid_d = capture | (rsp_valid_q & ~bus.rsp_ready);
    rd1_d       = capture ? rf_rd1_i : rd1_q;
    rd2_d       = capture ? rf_rd2_i : rd2_q;
    wp_d        = wp_q + (PW+1)'(push);
    rp_d        = rp_q + (PW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= ISS_IDLE;
      wp_q        <= '0;
      rp_q        <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      a3_q        <= '0;
      wd3_q       <= '0;
      rsp_valid_q <= 1'b0;
      rd1_q       <= '0;
      rd2_q       <= '0;
    end else begin
      st_q        <= st_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      a3_q        <= a3_d;
      wd3_q       <= wd3_d;
      rsp_valid_q <= rsp_valid_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q[PW-1:0]] <= inc;
  end
  assign bus.cmd_ready = ~full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rd1   = rd1_q;
  assign bus.rsp_rd2   = rd2_q;
  assign rf_we3_o      = st_q == ISS_WRITE;
  assign rf_a1_o       = a1_q;
  assign rf_a2_o       = a2_q;
  assign rf_a3_o       = a3_q;
  assign rf_wd3_o      = wd3_q;
  assign busy_o        = ~empty | (st_q != ISS_IDLE) | rsp_valid_q;
endmodule
